// File: rtl/axis_packet_gen.sv
// AXI-Stream test-pattern source: a run of fixed-length packets whose 32-bit lanes carry a beat sequence count.
// Optional inter-packet gap insertion is enabled by defining AXIS_PACKET_GEN_GAP_EN.
`timescale 1ns/1ps

module axis_packet_gen #(
    parameter int unsigned DW = 512
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            START,
    input  logic [31:0]     NUM_PACKETS,
    input  logic [15:0]     BEATS_PER_PACKET,
`ifdef AXIS_PACKET_GEN_GAP_EN
    input  logic [15:0]     GAP_CYCLES,
`endif
    output logic            BUSY,
    output logic            DONE,
    output logic [DW-1:0]   AXIS_OUT_TDATA,
    output logic [DW/8-1:0] AXIS_OUT_TKEEP,
    output logic            AXIS_OUT_TLAST,
    output logic            AXIS_OUT_TVALID,
    input  logic            AXIS_OUT_TREADY
);

    localparam int unsigned LANES = DW / 32;
    localparam int unsigned KW    = DW / 8;

`ifdef AXIS_PACKET_GEN_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_FINISH = 2'd2,
        S_GAP    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_FINISH = 2'd2
    } state_t;
`endif

    state_t      state;
    logic        busy_q;
    logic        done_q;
    logic        tvalid_q;
    logic        tlast_q;
    logic [31:0] seq_q;
    logic [15:0] beat_idx;
    logic [15:0] beats_cfg;
    logic [31:0] pkts_left;
`ifdef AXIS_PACKET_GEN_GAP_EN
    logic [15:0] gap_cfg;
    logic [15:0] gap_cnt;
`endif

    logic hs_c;

    // Handshake is qualified by resetn so nothing is consumed while in reset.
    assign hs_c = tvalid_q & AXIS_OUT_TREADY & resetn;

    // Run controller: configuration capture, beat/packet counting and completion.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            seq_q     <= 32'd0;
            beat_idx  <= 16'd0;
            beats_cfg <= 16'd1;
            pkts_left <= 32'd0;
`ifdef AXIS_PACKET_GEN_GAP_EN
            gap_cfg   <= 16'd0;
            gap_cnt   <= 16'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        pkts_left <= NUM_PACKETS;
                        beats_cfg <= (BEATS_PER_PACKET == 16'd0) ? 16'd1 : BEATS_PER_PACKET;
`ifdef AXIS_PACKET_GEN_GAP_EN
                        gap_cfg   <= GAP_CYCLES;
`endif
                        busy_q    <= 1'b1;
                        seq_q     <= 32'd0;
                        beat_idx  <= 16'd0;
                        if (NUM_PACKETS == 32'd0) begin
                            state <= S_FINISH;
                        end else begin
                            state    <= S_SEND;
                            tvalid_q <= 1'b1;
                            tlast_q  <= (BEATS_PER_PACKET <= 16'd1);
                        end
                    end
                end

                S_SEND: begin
                    if (hs_c) begin
                        seq_q <= seq_q + 32'd1;
                        if (tlast_q) begin
                            pkts_left <= pkts_left - 32'd1;
                            beat_idx  <= 16'd0;
                            if (pkts_left == 32'd1) begin
                                state    <= S_FINISH;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
`ifdef AXIS_PACKET_GEN_GAP_EN
                            end else if (gap_cfg != 16'd0) begin
                                state    <= S_GAP;
                                gap_cnt  <= gap_cfg;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
`endif
                            end else begin
                                tlast_q <= (beats_cfg == 16'd1);
                            end
                        end else begin
                            beat_idx <= beat_idx + 16'd1;
                            // Next beat is the last when beat_idx+1 == beats_cfg-1.
                            tlast_q  <= ({1'b0, beat_idx} + 17'd2 == {1'b0, beats_cfg});
                        end
                    end
                end

`ifdef AXIS_PACKET_GEN_GAP_EN
                S_GAP: begin
                    gap_cnt <= gap_cnt - 16'd1;
                    if (gap_cnt == 16'd1) begin
                        state    <= S_SEND;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (beats_cfg == 16'd1);
                    end
                end
`endif

                S_FINISH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    state    <= S_IDLE;
                    busy_q   <= 1'b0;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign AXIS_OUT_TDATA  = {LANES{seq_q}};
    assign AXIS_OUT_TKEEP  = {KW{1'b1}};
    assign AXIS_OUT_TLAST  = tlast_q;
    assign AXIS_OUT_TVALID = tvalid_q & resetn;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Randomized bench for axis_packet_gen: a per-run expected beat list built from the packet rules,
// consumed by a per-cycle checker under random backpressure, plus literal timing expectations.
`timescale 1ns/1ps

module tb_axis_packet_gen;

    localparam int unsigned DW    = 512;
    localparam int unsigned LANES = DW / 32;
    localparam int unsigned KW    = DW / 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            START = 1'b0;
    logic [31:0]     NUM_PACKETS = 32'd0;
    logic [15:0]     BEATS_PER_PACKET = 16'd0;
`ifdef AXIS_PACKET_GEN_GAP_EN
    logic [15:0]     GAP_CYCLES = 16'd0;
`endif
    logic            BUSY;
    logic            DONE;
    logic [DW-1:0]   TDATA;
    logic [KW-1:0]   TKEEP;
    logic            TLAST;
    logic            TVALID;
    logic            TREADY = 1'b1;

    axis_packet_gen #(.DW(DW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .START            (START),
        .NUM_PACKETS      (NUM_PACKETS),
        .BEATS_PER_PACKET (BEATS_PER_PACKET),
`ifdef AXIS_PACKET_GEN_GAP_EN
        .GAP_CYCLES       (GAP_CYCLES),
`endif
        .BUSY             (BUSY),
        .DONE             (DONE),
        .AXIS_OUT_TDATA   (TDATA),
        .AXIS_OUT_TKEEP   (TKEEP),
        .AXIS_OUT_TLAST   (TLAST),
        .AXIS_OUT_TVALID  (TVALID),
        .AXIS_OUT_TREADY  (TREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int          rdy_mode = 0;

    int unsigned rd_ptr = 0;
    int unsigned beats_total = 0;
    int unsigned tlast_total = 0;
    int unsigned busy_total = 0;
    int unsigned done_total = 0;
    int unsigned done_cyc = 0;
    int unsigned valid_rise_cyc = 0;
    logic [31:0] last_data = 32'd0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pl = 1'b0;
    logic [DW-1:0] pd = '0;

    int unsigned c0;
    int unsigned r_beats, r_tlast, r_busy, r_done;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready pattern: 0 = always ready, 1 = random 50%, other = stalled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       TREADY = 1'b1;
                1:       TREADY = 1'($urandom_range(0, 1));
                default: TREADY = 1'b0;
            endcase
        end
    end

    // Per-cycle output checker against the expected beat list.
    always @(negedge clk) begin
        if (!resetn) begin
            chk("tvalid_in_reset", 64'(TVALID), 64'd0);
            rd_ptr <= exp_q.size();
            pv     <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_tvalid", 64'(TVALID), 64'd1);
                chk("hold_tlast", 64'(TLAST), 64'(pl));
                chk("hold_tdata", 64'(TDATA == pd), 64'd1);
            end
            if (TVALID) begin
                chk("beat_expected", 64'(rd_ptr < exp_q.size()), 64'd1);
                if (rd_ptr < exp_q.size()) begin
                    chk("tdata_lane0", 64'(TDATA[31:0]), 64'(exp_q[rd_ptr].data));
                    chk("tdata_all_lanes", 64'(TDATA == {LANES{exp_q[rd_ptr].data}}), 64'd1);
                    chk("tlast", 64'(TLAST), 64'(exp_q[rd_ptr].last));
                    chk("tkeep", 64'(TKEEP), 64'({KW{1'b1}}));
                    if (TREADY) begin
                        rd_ptr      <= rd_ptr + 1;
                        beats_total <= beats_total + 1;
                        tlast_total <= tlast_total + 32'(TLAST);
                        last_data   <= TDATA[31:0];
                    end
                end
                if (!pv) valid_rise_cyc <= cyc;
            end
            if (BUSY) busy_total <= busy_total + 1;
            if (DONE) begin
                done_total <= done_total + 1;
                done_cyc   <= cyc;
            end
            pv <= TVALID;
            pr <= TREADY;
            pl <= TLAST;
            pd <= TDATA;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Builds the expected beat list for a run and issues the START pulse.
    task automatic start_run(input int unsigned n, input int unsigned b, input int unsigned g);
        int unsigned be;
        int unsigned k;
        be = (b == 0) ? 1 : b;
        k  = 0;
        for (int p = 0; p < int'(n); p++) begin
            for (int i = 0; i < int'(be); i++) begin
                exp_q.push_back('{data: 32'(k), last: (i == int'(be) - 1)});
                k++;
            end
        end
        NUM_PACKETS      = 32'(n);
        BEATS_PER_PACKET = 16'(b);
`ifdef AXIS_PACKET_GEN_GAP_EN
        GAP_CYCLES       = 16'(g);
`endif
        START = 1'b1;
        c0    = cyc;
        tick();
        START            = 1'b0;
        NUM_PACKETS      = $urandom;
        BEATS_PER_PACKET = 16'($urandom);
`ifdef AXIS_PACKET_GEN_GAP_EN
        GAP_CYCLES       = 16'($urandom);
`else
        if (g != 0) $display("note: gap request %0d ignored in this build", g);
`endif
    endtask

    task automatic run_check(input int unsigned n, input int unsigned b, input int mode,
                             input int unsigned budget);
        int unsigned d0, bt0, tl0, bu0, be;
        d0  = done_total;
        bt0 = beats_total;
        tl0 = tlast_total;
        bu0 = busy_total;
        be  = (b == 0) ? 1 : b;
        rdy_mode = mode;
        start_run(n, b, 0);
        for (int unsigned i = 0; i < budget; i++) begin
            if (done_total != d0) break;
            tick();
        end
        chk("run_completes", 64'(done_total != d0), 64'd1);
        tick();
        tick();
        r_beats = beats_total - bt0;
        r_tlast = tlast_total - tl0;
        r_busy  = busy_total - bu0;
        r_done  = done_total - d0;
        chk("beat_count", 64'(r_beats), 64'(n * be));
        chk("tlast_count", 64'(r_tlast), 64'(n));
        chk("done_pulses", 64'(r_done), 64'd1);
        chk("busy_until_done", 64'(r_busy), 64'(done_cyc - c0 - 1));
        chk("queue_drained", 64'(rd_ptr), 64'(exp_q.size()));
    endtask

    initial begin
        int unsigned d0, bt0;

        resetn = 1'b0;
        repeat (3) tick();
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_done", 64'(DONE), 64'd0);
        chk("reset_tvalid", 64'(TVALID), 64'd0);
        chk("reset_tlast", 64'(TLAST), 64'd0);
        resetn = 1'b1;
        repeat (2) tick();

        // 3 x 4 beats, always ready: exact timing pinned by literals.
        run_check(3, 4, 0, 100);
        chk("A_first_valid_latency", 64'(valid_rise_cyc - c0), 64'd1);
        chk("A_beats", 64'(r_beats), 64'd12);
        chk("A_tlasts", 64'(r_tlast), 64'd3);
        chk("A_last_value", 64'(last_data), 64'd11);
        chk("A_done_latency", 64'(done_cyc - c0), 64'd14);
        chk("A_busy_cycles", 64'(r_busy), 64'd13);

        // Same configuration under random backpressure.
        run_check(3, 4, 1, 400);
        chk("B_last_value", 64'(last_data), 64'd11);

        // Zero packets: no beats, DONE two cycles after START.
        run_check(0, 4, 0, 20);
        chk("C_no_beats", 64'(r_beats), 64'd0);
        chk("C_done_latency", 64'(done_cyc - c0), 64'd2);

        // Zero beats per packet behaves as one.
        run_check(2, 0, 0, 50);
        chk("D_beats", 64'(r_beats), 64'd2);
        chk("D_last_value", 64'(last_data), 64'd1);

        // Reset mid-run (with a START in the reset cycle), then a fresh run.
        d0  = done_total;
        bt0 = beats_total;
        rdy_mode = 1;
        start_run(4, 8, 0);
        for (int i = 0; i < 200; i++) begin
            if (beats_total - bt0 >= 5) break;
            tick();
        end
        chk("E_reached_beat5", 64'(beats_total - bt0 >= 5), 64'd1);
        resetn = 1'b0;
        START  = 1'b1;
        NUM_PACKETS = 32'd1;
        BEATS_PER_PACKET = 16'd1;
        tick();
        resetn = 1'b1;
        START  = 1'b0;
        repeat (10) tick();
        chk("E_no_done", 64'(done_total - d0), 64'd0);
        chk("E_idle_after_reset", 64'(BUSY), 64'd0);
        run_check(2, 3, 1, 300);
        chk("E_restart_last_value", 64'(last_data), 64'd5);

        // START pulses while busy must be ignored.
        d0  = done_total;
        bt0 = beats_total;
        rdy_mode = 1;
        start_run(2, 5, 0);
        for (int i = 0; i < 300; i++) begin
            if (done_total != d0) break;
            START = BUSY && (i % 3 == 0);
            NUM_PACKETS = 32'd7;
            BEATS_PER_PACKET = 16'd3;
            tick();
        end
        START = 1'b0;
        repeat (8) tick();
        chk("F_beats_original_only", 64'(beats_total - bt0), 64'd10);
        chk("F_one_done", 64'(done_total - d0), 64'd1);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            run_check($urandom_range(1, 4), $urandom_range(0, 5), $urandom_range(0, 1), 600);
        end

`ifdef AXIS_PACKET_GEN_GAP_EN
        begin
            logic [6:0] pat;
            pat = 7'b1100011;
            d0 = done_total;
            rdy_mode = 0;
            start_run(2, 2, 3);
            for (int i = 0; i < 7; i++) begin
                chk("G_gap_tvalid", 64'(TVALID), 64'(pat[6 - i]));
                tick();
            end
            for (int i = 0; i < 20; i++) begin
                if (done_total != d0) break;
                tick();
            end
            chk("G_done", 64'(done_total - d0), 64'd1);
            chk("G_done_latency", 64'(done_cyc - c0), 64'd9);
        end
`endif

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_packet_gen.md
Name: axis_packet_gen

Overview:
- Test-pattern source that emits a burst of fixed-length AXI-Stream packets with a deterministic, checkable payload.
- Sits directly upstream of the bc_emu rate limiter; its output stream is the limiter's input stream.
- Software starts a run with START and observes completion through BUSY and DONE.
- Downstream backpressure, including throttling by the rate limiter, is fully honoured.

Parameters:
- DW, 512, stream data width in bits; multiple of 32.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- START  in  1  single-cycle pulse that begins a run
- NUM_PACKETS  in  32  packets per run; sampled on START
- BEATS_PER_PACKET  in  16  data beats per packet; sampled on START
- BUSY  out  1  high while a run is in progress
- DONE  out  1  one-cycle pulse when a run completes
- AXIS_OUT_TDATA  out  DW  payload
- AXIS_OUT_TKEEP  out  DW/8  byte enables; always all-ones
- AXIS_OUT_TLAST  out  1  marks the final beat of each packet
- AXIS_OUT_TVALID  out  1  beat valid
- AXIS_OUT_TREADY  in  1  downstream ready

Behaviour:
- Reset values (the cycle after resetn is sampled low): BUSY=0, DONE=0, TVALID=0, TLAST=0, beat sequence counter=0, state=IDLE.
- TVALID and TREADY-dependent logic are additionally gated with resetn, so TVALID is 0 during any cycle in which resetn=0.
- State machine:
  - IDLE:
    - START=1 latches NUM_PACKETS into pkts_left and max(BEATS_PER_PACKET,1) into beats_cfg; BUSY goes to 1.
    - Next state is SEND, or FINISH if NUM_PACKETS=0.
  - SEND:
    - TVALID=1; beat_idx counts 0..beats_cfg-1; TLAST=1 when beat_idx==beats_cfg-1.
    - On each handshake (TVALID&TREADY) the beat sequence counter increments and beat_idx advances.
    - On a handshake with TLAST=1: pkts_left decrements and beat_idx clears.
    - If pkts_left was 1, next state is FINISH; otherwise SEND (back-to-back) or GAP (optional feature).
  - FINISH: one cycle; DONE=1, BUSY=0; next state IDLE.
- Latency: first TVALID appears 1 cycle after the START cycle.
- Throughput: with TREADY held high, one beat per cycle, no bubbles between packets (feature disabled).
- Payload:
  - Every 32-bit lane of TDATA holds the 32-bit beat sequence counter value for that beat.
  - The counter starts at 0 each run and wraps 0xFFFFFFFF to 0 without error.
- AXIS rule: once TVALID=1, TDATA, TLAST and TVALID hold stable until a handshake occurs. TREADY toggling never drops or duplicates a beat.
- START while BUSY=1 is ignored. START in the same cycle as resetn=0 is ignored.
- Config inputs are don't-care except on the START cycle; changes during a run have no effect.
- Reset mid-run: the run aborts with no DONE pulse; the next START restarts the beat sequence counter at 0.
- Width rules:
  - pkts_left is 32 bits; NUM_PACKETS=0xFFFFFFFF is legal.
  - beat_idx is 16 bits; BEATS_PER_PACKET=0 is treated as 1.

Optional Feature:
- Macro: AXIS_PACKET_GEN_GAP_EN
- Defined:
  - Adds input GAP_CYCLES [15:0], sampled on START.
  - After each packet except the last, the FSM enters GAP and holds TVALID=0 for exactly GAP_CYCLES cycles, then returns to SEND.
  - GAP_CYCLES=0 gives back-to-back packets (no GAP state visit).
  - The last packet goes straight to FINISH.
- Undefined: no GAP_CYCLES port, no GAP state; packets are always back-to-back.

Test Plan:
- START, NUM_PACKETS=3, BEATS_PER_PACKET=4, TREADY=1:
  - 12 consecutive beats, lane values 0..11, TLAST on beats 3, 7, 11.
  - DONE pulses once, 1 cycle after beat 11; BUSY high for exactly 13 cycles.
- Same configuration, TREADY random at 50%:
  - Identical beat sequence; TDATA/TLAST stable while TVALID&!TREADY.
  - No beat lost or duplicated (scoreboard check).
- NUM_PACKETS=0: no TVALID; DONE pulses 2 cycles after START. BEATS_PER_PACKET=0, NUM_PACKETS=2: 2 single-beat packets, each with TLAST=1, values 0 and 1.
- resetn pulsed low mid-run at beat 5 of a NUM_PACKETS=4, BEATS_PER_PACKET=8 run:
  - TVALID=0 in the reset cycle; no DONE.
  - A subsequent START restarts the sequence at 0.
- START reasserted while BUSY=1 → ignored: total beat count equals that of the original run only.
- With AXIS_PACKET_GEN_GAP_EN, NUM_PACKETS=2, BEATS_PER_PACKET=2, GAP_CYCLES=3, TREADY=1: TVALID pattern 1,1,0,0,0,1,1, then DONE.
